// File: rtl/tree_sum_accumulator.sv
// tree_sum_accumulator
// Collects NUM_CHUNKS consecutive partial sums from the 8-input tree adder,
// adds a bias sampled on the first beat, then applies optional ReLU and
// saturation to WIDTH before presenting the result on a valid/ready handshake.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   en           global enable; 0 freezes every register
//   clr          synchronous clear (effective only with en=1)
//   in_valid     partial sum present on in_data
//   in_data      signed partial sum
//   bias_in      signed bias, captured on the first beat of a vector
//   in_ready     block can accept a beat (decoded from state)
//   out_valid    result valid
//   out_ready    downstream accepts result
//   out_data     signed saturated result
//   err_overrun  sticky: beat offered while in_ready=0
module tree_sum_accumulator #(
  parameter int WIDTH      = 16,
  parameter int NUM_CHUNKS = 4,
  parameter int RELU_EN    = 1,
  parameter int ACC_WIDTH  = WIDTH + $clog2(NUM_CHUNKS + 1) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic [WIDTH-1:0] bias_in,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             err_overrun
);

  localparam int CNT_W = (NUM_CHUNKS < 2) ? 1 : $clog2(NUM_CHUNKS + 1);
  localparam int EXT_W = ACC_WIDTH - WIDTH;

  // Saturation bounds expressed at accumulator width.
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(EXT_W + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(EXT_W + 1){1'b1}}, {(WIDTH - 1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    SAT   = 2'd2,
    OUT   = 2'd3
  } state_t;

  state_t                        r_state, w_state_nxt;
  logic signed [ACC_WIDTH-1:0]   r_acc, w_acc_nxt;
  logic        [CNT_W-1:0]       r_count, w_cnt_nxt;
  logic        [WIDTH-1:0]       r_out_data, w_out_data_nxt;
  logic                          r_out_valid, w_out_valid_nxt;
  logic                          r_err, w_err_nxt;

  logic signed [ACC_WIDTH-1:0]   w_in_ext, w_bias_ext, w_v;
  logic        [CNT_W-1:0]       w_cnt_inc;
  logic        [WIDTH-1:0]       w_sat;
  logic                          w_in_ready;

  assign w_in_ext   = {{EXT_W{in_data[WIDTH-1]}}, in_data};
  assign w_bias_ext = {{EXT_W{bias_in[WIDTH-1]}}, bias_in};
  assign w_cnt_inc  = r_count + CNT_W'(1);
  assign w_in_ready = (r_state == IDLE) || (r_state == ACCUM);

  // ReLU first, then clamp to the output range.
  always_comb begin
    w_v = r_acc;
    if ((RELU_EN != 0) && r_acc[ACC_WIDTH-1]) w_v = '0;
    if (w_v > SAT_MAX)      w_sat = SAT_MAX[WIDTH-1:0];
    else if (w_v < SAT_MIN) w_sat = SAT_MIN[WIDTH-1:0];
    else                    w_sat = w_v[WIDTH-1:0];
  end

  // Next-state / datapath. Everything here is applied only when en=1.
  always_comb begin
    w_state_nxt     = r_state;
    w_acc_nxt       = r_acc;
    w_cnt_nxt       = r_count;
    w_out_data_nxt  = r_out_data;
    w_out_valid_nxt = r_out_valid;
    w_err_nxt       = r_err | (in_valid & ~w_in_ready);
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_acc_nxt   = w_bias_ext + w_in_ext;
          w_cnt_nxt   = CNT_W'(1);
          w_state_nxt = (NUM_CHUNKS == 1) ? SAT : ACCUM;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          w_acc_nxt = r_acc + w_in_ext;
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == CNT_W'(NUM_CHUNKS)) w_state_nxt = SAT;
        end
      end
      SAT: begin
        w_out_data_nxt  = w_sat;
        w_out_valid_nxt = 1'b1;
        w_state_nxt     = OUT;
      end
      OUT: begin
        if (out_ready) begin
          w_out_valid_nxt = 1'b0;
          w_acc_nxt       = '0;
          w_cnt_nxt       = '0;
          w_state_nxt     = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_count     <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_err       <= 1'b0;
    end else if (en) begin
      if (clr) begin
        r_state     <= IDLE;
        r_acc       <= '0;
        r_count     <= '0;
        r_out_data  <= '0;
        r_out_valid <= 1'b0;
        r_err       <= 1'b0;
      end else begin
        r_state     <= w_state_nxt;
        r_acc       <= w_acc_nxt;
        r_count     <= w_cnt_nxt;
        r_out_data  <= w_out_data_nxt;
        r_out_valid <= w_out_valid_nxt;
        r_err       <= w_err_nxt;
      end
    end
  end

  assign in_ready    = w_in_ready;
  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign err_overrun = r_err;

endmodule

// File: tb/tb_tree_sum_accumulator.sv
// Directed bench: two instances (ReLU and linear) share all inputs.
module tb_tree_sum_accumulator;
  localparam int W = 16;

  logic         gclk = 1'b0;
  logic         rst_n, en, clr, in_valid, out_ready;
  logic [W-1:0] in_data, bias_in;
  logic         rl_in_ready, rl_out_valid, rl_err;
  logic         ln_in_ready, ln_out_valid, ln_err;
  logic [W-1:0] rl_out_data, ln_out_data;

  int n_cmp = 0;
  int n_err = 0;

  always #5 gclk = ~gclk;

  tree_sum_accumulator #(.WIDTH(W), .NUM_CHUNKS(4), .RELU_EN(1)) u_relu (
    .clk(gclk), .rst_n(rst_n), .en(en), .clr(clr),
    .in_valid(in_valid), .in_data(in_data), .bias_in(bias_in),
    .in_ready(rl_in_ready), .out_valid(rl_out_valid), .out_ready(out_ready),
    .out_data(rl_out_data), .err_overrun(rl_err));

  tree_sum_accumulator #(.WIDTH(W), .NUM_CHUNKS(4), .RELU_EN(0)) u_lin (
    .clk(gclk), .rst_n(rst_n), .en(en), .clr(clr),
    .in_valid(in_valid), .in_data(in_data), .bias_in(bias_in),
    .in_ready(ln_in_ready), .out_valid(ln_out_valid), .out_ready(out_ready),
    .out_data(ln_out_data), .err_overrun(ln_err));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge gclk);
    #1;
  endtask

  task automatic beat(input logic [W-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic send4(input logic [W-1:0] b, input logic [W-1:0] d0, input logic [W-1:0] d1,
                       input logic [W-1:0] d2, input logic [W-1:0] d3);
    bias_in = b;
    beat(d0); beat(d1); beat(d2); beat(d3);
  endtask

  // Bounded wait for a result on the ReLU instance.
  task automatic wait_out(input string tag);
    int k;
    k = 0;
    while (!rl_out_valid && k < 12) begin
      step();
      k++;
    end
    chk({tag, "_vld"}, 32'(rl_out_valid), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_data = '0; bias_in = '0;
    #1;
    chk("rst_vld",  32'(rl_out_valid), 32'd0);
    chk("rst_data", 32'(rl_out_data),  32'd0);
    chk("rst_err",  32'(rl_err),       32'd0);
    chk("rst_rdy",  32'(rl_in_ready),  32'd1);
    step(); step();
    rst_n = 1'b1;
    step();

    // Back-to-back vector, exact latency and in_ready low window.
    chk("t1_rdy0", 32'(rl_in_ready), 32'd1);
    send4(16'd5, 16'd10, 16'd20, 16'd30, 16'd40);
    chk("t1_sat_vld", 32'(rl_out_valid), 32'd0);
    chk("t1_sat_rdy", 32'(rl_in_ready),  32'd0);
    step();
    chk("t1_vld",  32'(rl_out_valid), 32'd1);
    chk("t1_data", 32'(rl_out_data),  32'd105);
    chk("t1_lin",  32'(ln_out_data),  32'd105);
    chk("t1_rdy1", 32'(rl_in_ready),  32'd0);
    step();
    chk("t1_done_vld", 32'(rl_out_valid), 32'd0);
    chk("t1_done_rdy", 32'(rl_in_ready),  32'd1);

    // Negative sum: ReLU clamps, linear keeps -103.
    send4(16'd0, 16'hFF9C, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    wait_out("t2");
    chk("t2_relu", 32'(rl_out_data), 32'h0);
    chk("t2_lin",  32'(ln_out_data), 32'hFF99);
    step();

    // Saturation both directions.
    send4(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    wait_out("t3p");
    chk("t3p_lin",  32'(ln_out_data), 32'h7FFF);
    chk("t3p_relu", 32'(rl_out_data), 32'h7FFF);
    step();
    send4(16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000);
    wait_out("t3n");
    chk("t3n_lin",  32'(ln_out_data), 32'h8000);
    chk("t3n_relu", 32'(rl_out_data), 32'h0);
    step();

    // Backpressure with an overrun beat in the stall window.
    out_ready = 1'b0;
    send4(16'd5, 16'd10, 16'd20, 16'd30, 16'd40);
    wait_out("t4");
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_vld",  32'(rl_out_valid), 32'd1);
      chk("t4_hold_data", 32'(rl_out_data),  32'd105);
      chk("t4_hold_rdy",  32'(rl_in_ready),  32'd0);
      if (i == 2) beat(16'd99);
      else step();
    end
    chk("t4_err",  32'(rl_err),      32'd1);
    chk("t4_data", 32'(rl_out_data), 32'd105);
    out_ready = 1'b1;
    step();
    chk("t4_rel_vld", 32'(rl_out_valid), 32'd0);
    send4(16'd0, 16'd1, 16'd1, 16'd1, 16'd1);
    wait_out("t4b");
    chk("t4b_data", 32'(rl_out_data), 32'd4);
    chk("t4b_err",  32'(rl_err),      32'd1);
    step();

    // Gaps plus en stall with a beat held on the bus.
    bias_in = 16'd5;
    beat(16'd10); step(); step(); step();
    beat(16'd20); step(); step(); step();
    en = 1'b0; in_valid = 1'b1; in_data = 16'd30;
    step(); step();
    chk("t5_frz_rdy", 32'(rl_in_ready), 32'd1);
    en = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step(); step();
    chk("t5_novld", 32'(rl_out_valid), 32'd0);
    beat(16'd40);
    wait_out("t5");
    chk("t5_data", 32'(rl_out_data), 32'd105);
    step();

    // Async reset mid-vector.
    bias_in = 16'd77;
    beat(16'd500); beat(16'd600);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_vld",  32'(rl_out_valid), 32'd0);
    chk("t6_rst_data", 32'(rl_out_data),  32'd0);
    chk("t6_rst_err",  32'(rl_err),       32'd0);
    #1 rst_n = 1'b1;
    step();
    send4(16'd5, 16'd10, 16'd20, 16'd30, 16'd40);
    wait_out("t6");
    chk("t6_data", 32'(rl_out_data), 32'd105);
    step();

    // clr mid-vector.
    bias_in = 16'd77;
    beat(16'd500); beat(16'd600);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("t7_clr_data", 32'(rl_out_data), 32'd0);
    chk("t7_clr_rdy",  32'(rl_in_ready), 32'd1);
    send4(16'd5, 16'd10, 16'd20, 16'd30, 16'd40);
    wait_out("t7");
    chk("t7_data", 32'(rl_out_data), 32'd105);
    step();

    // clr colliding with handshake: result lost, flag cleared.
    out_ready = 1'b0;
    send4(16'd0, 16'd2, 16'd2, 16'd2, 16'd2);
    wait_out("t8");
    beat(16'd1);
    chk("t8_err", 32'(rl_err), 32'd1);
    out_ready = 1'b1; clr = 1'b1;
    step();
    clr = 1'b0;
    chk("t8_vld",  32'(rl_out_valid), 32'd0);
    chk("t8_data", 32'(rl_out_data),  32'd0);
    chk("t8_err0", 32'(rl_err),       32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/tree_sum_accumulator.md
Name: tree_sum_accumulator

Overview:
- Downstream consumer of the 8-input pipelined tree adder.
- Accumulates NUM_CHUNKS consecutive 8-wide partial sums into one neuron pre-activation, adds a bias, and applies optional ReLU with saturation to WIDTH.
- Presents the result on a valid/ready handshake to the next VAE layer stage.
- The upstream controller delays its valid by the tree adder latency (4 enabled cycles) and drives in_valid here.

Parameters:
- WIDTH, 16, two's-complement data width of in_data, bias_in, out_data.
- NUM_CHUNKS, 4, partial sums per result; must be >= 1.
- RELU_EN, 1, 1 = clamp negative results to 0 before saturation; 0 = linear.
- ACC_WIDTH, WIDTH+$clog2(NUM_CHUNKS+1)+1, internal accumulator width; guarantees no internal overflow.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  global enable; 0 freezes all state (outputs held).
- clr  input  1  synchronous clear, priority over everything except rst_n, acts only when en=1.
- in_valid  input  1  partial sum present on in_data.
- in_data  input  WIDTH  signed partial sum from tree adder.
- bias_in  input  WIDTH  signed bias, sampled on the first accepted beat of a vector.
- in_ready  output  1  block can accept a beat (combinational from state).
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_data  output  WIDTH  signed saturated (and optionally ReLU'd) result.
- err_overrun  output  1  sticky: beat arrived while in_ready=0.

Behaviour:
- Reset (rst_n=0, async): state=IDLE, acc=0, count=0, out_data=0, out_valid=0, err_overrun=0.
- en=0: no state, acc, count, output or flag changes; handshakes ignored.
- clr=1 with en=1: same values as reset on the edge; an in-flight vector is discarded.
- in_ready=1 in IDLE and ACCUM; 0 in SAT and OUT.
- Beat accepted = en & in_valid & in_ready at the rising edge.
- IDLE: on an accepted beat, acc <= sext(bias_in) + sext(in_data) and count <= 1.
  - If NUM_CHUNKS==1, go to SAT; else go to ACCUM.
- ACCUM: on an accepted beat, acc <= acc + sext(in_data) and count <= count+1.
  - When the beat makes count==NUM_CHUNKS, go to SAT.
  - Gaps (in_valid=0) are allowed and hold state.
- SAT: one cycle. Compute v = (RELU_EN && acc<0) ? 0 : acc.
  - Saturate v to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - Register the result into out_data, set out_valid=1, go to OUT.
- OUT: out_valid and out_data held stable while out_ready=0.
  - On en & out_ready: out_valid <= 0, acc <= 0, count <= 0, state <= IDLE.
  - in_ready rises the cycle after the handshake.
- Latency: if the last beat is accepted at edge k (en continuously 1), out_valid=1 after edge k+1. Minimum vector-to-vector spacing is NUM_CHUNKS+2 cycles with out_ready held 1.
- Overrun: in_valid=1 with en=1 while in_ready=0 sets err_overrun.
  - The beat is dropped; acc and out_data are unaffected.
  - err_overrun is cleared only by rst_n or clr.
- Arithmetic: all additions are signed at ACC_WIDTH with sign extension. There is no wrap inside the accumulator; saturation happens only at the SAT stage.
- Simultaneous clr and handshake: clr wins; out_valid=0, and the result is lost without error.
- Reset mid-operation: the partial acc is discarded. The next vector starts cleanly with bias re-sampled.

Test Plan:
- WIDTH=16, NUM_CHUNKS=4, RELU_EN=1, out_ready=1: bias=5, beats 10,20,30,40 back-to-back -> out_valid after edge k+1, out_data=105; in_ready low for exactly 2 cycles.
- Negative path: bias=0, beats -100,-1,-1,-1 -> out_data=0 with RELU_EN=1. Same vector with RELU_EN=0 -> out_data=0xFF99 (-103).
- Saturation, RELU_EN=0: bias=0x7FFF, 4 beats of 0x7FFF -> 0x7FFF. bias=0x8000, 4 beats of 0x8000 -> 0x8000.
- Backpressure: out_ready=0 for 5 cycles after result 105 -> out_valid, out_data stable, in_ready=0.
  - An in_valid pulse with data 99 during this window sets err_overrun=1; result still 105.
  - After out_ready=1, the next vector 1,1,1,1 with bias 0 -> 4.
- Gaps and en stall: beats 10,20,30,40 with 3 idle cycles between each and en=0 for 2 cycles mid-vector -> out_data=105 (with bias 5); no extra beats counted.
- Mid-operation abort: after 2 beats, pulse rst_n low -> all outputs 0 immediately.
  - Repeat with a clr pulse -> outputs 0 after the edge.
  - In both cases the following full vector (bias 5; 10,20,30,40) -> 105 with no carry-over.
